// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: bursts one-word reads from SRAM port B into a credit-throttled output FIFO.
// Optional build macro SRAM_RD_CHECK_EN adds a PAT_BASE+address data checker (chk_err, chk_cnt).
module sram_rd_streamer #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
`ifdef SRAM_RD_CHECK_EN
    ,
    parameter logic [DATA_W-1:0] PAT_BASE = DATA_W'(32'hECEB0000)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef SRAM_RD_CHECK_EN
    ,
    output logic              chk_err,
    output logic [15:0]       chk_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [RD_LAT-1:0]   vp;
    logic [RD_LAT-1:0]   lp;
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_l;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [CW-1:0]       cnt;
    logic [OW-1:0]       occ;
    logic                issue;
    logic                push;
    logic                pop;

    // Credit: buffered words plus reads still travelling through the macro.
    always_comb begin
        occ = OW'(cnt);
        for (int i = 0; i < RD_LAT; i++) occ = occ + OW'(vp[i]);
    end

    assign issue     = state == ISSUE && occ < OW'(FIFO_DEPTH);
    assign push      = vp[RD_LAT-1];
    assign pop       = out_valid && out_ready;
    assign out_valid = cnt != '0;
    assign out_data  = mem_d[rptr];
    assign out_last  = out_valid && mem_l[rptr];
    assign sram_cen  = !issue;
    assign sram_wen  = 1'b1;
    assign sram_addr = addr;
    assign busy      = state == ISSUE || state == DRAIN;
    assign done      = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            vp        <= '0;
            lp        <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            mem_l     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= len;
                    state     <= len == '0 ? DONE : ISSUE;
                end
                ISSUE: if (issue) begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == 1) state <= DRAIN;
                end
                // Leave as the final word hands over so done lands the very next cycle.
                DRAIN: if (vp == '0 && (cnt == '0 || (cnt == 1 && pop))) state <= DONE;
                default: state <= IDLE;
            endcase
            vp[0] <= issue;
            lp[0] <= issue && remaining == 1;
            for (int i = 1; i < RD_LAT; i++) begin
                vp[i] <= vp[i-1];
                lp[i] <= lp[i-1];
            end
            if (push) begin
                mem_d[wptr] <= sram_q;
                mem_l[wptr] <= lp[RD_LAT-1];
                wptr        <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

`ifdef SRAM_RD_CHECK_EN
    logic [ADDR_W-1:0] ap [RD_LAT];

    always_ff @(posedge clk) begin
        ap[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
        if (rst || (state == IDLE && start)) begin
            chk_err <= 1'b0;
            chk_cnt <= '0;
        end else if (push && sram_q != PAT_BASE + DATA_W'(ap[RD_LAT-1])) begin
            chk_err <= 1'b1;
            if (chk_cnt != 16'hFFFF) chk_cnt <= chk_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: table-driven and random bursts against an SRAM model and a word-queue scoreboard.
// Build with SRAM_RD_CHECK_EN to also exercise the data checker.
module tb_sram_rd_streamer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] PAT = 32'hECEB0000;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                len;
        int                mode;
        int                poke;
        int                exp_words;
        logic [31:0]       first_w;
        logic [31:0]       last_w;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0] len = '0;
    logic busy, done, sram_cen, sram_wen, out_valid, out_last;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_q, out_data;
`ifdef SRAM_RD_CHECK_EN
    logic chk_err;
    logic [15:0] chk_cnt;
`endif

    always #5 clk = ~clk;

    sram_rd_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_q(sram_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SRAM_RD_CHECK_EN
        , .chk_err(chk_err), .chk_cnt(chk_cnt)
`endif
    );

    // SRAM macro model: data appears RD_LAT cycles after the CEN=0 cycle.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] qp [RD_LAT];
    always @(posedge clk) begin
        if (!sram_cen) qp[0] <= mem[sram_addr];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end
    assign sram_q = qp[RD_LAT-1];

    logic [DATA_W-1:0] exp_d [$];
    logic              exp_l [$];
    logic [ADDR_W-1:0] exp_a [$];

    int checks = 0, errors = 0;
    int cyc = 0, mode = 0, disc = 0;
    int n_cen = 0, n_words = 0, n_done = 0;
    int first_cen, first_val, first_hs, last_hs, done_cyc;
    logic [DATA_W-1:0] first_d, last_d, hold_d;
    logic hold_v = 1'b0, hold_l;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_burst(input logic [ADDR_W-1:0] b, input int l);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + ADDR_W'(i);
            exp_a.push_back(a);
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == l - 1);
        end
    endtask

    task automatic mon();
        logic hs;
        if (!rst) begin
            hs = out_valid && out_ready;
            if (!sram_cen) begin
                n_cen++;
                if (first_cen < 0) first_cen = cyc;
                chk("wen_high", sram_wen, 1'b1);
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_read: addr %0h, expected no read", sram_addr);
                end else chk("read_addr", sram_addr, exp_a.pop_front());
                chk("outstanding_ok", (n_cen - n_words - disc - int'(hs)) <= FIFO_DEPTH, 1'b1);
            end
            if (out_valid && first_val < 0) first_val = cyc;
            if (hold_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, hold_d);
                chk("stall_last", out_last, hold_l);
            end
            if (hs) begin
                n_words++;
                if (first_hs < 0) begin
                    first_hs = cyc;
                    first_d = out_data;
                end
                last_hs = cyc;
                last_d = out_data;
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: data %0h, expected none", out_data);
                end else begin
                    chk("data", out_data, exp_d.pop_front());
                    chk("last", out_last, exp_l.pop_front());
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 1'b0);
            end
        end else hold_v = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        out_ready = mode == 0 ? 1'b1 :
                    mode == 1 ? ((cyc % 30) >= 10 && cyc[0]) : 1'($urandom_range(0, 1));
        @(negedge clk);
        mon();
    endtask

    task automatic run_burst(input vec_t v);
        int c0, w0, d0;
        c0 = n_cen;
        w0 = n_words;
        d0 = n_done;
        first_cen = -1;
        first_val = -1;
        first_hs = -1;
        last_hs = -1;
        done_cyc = -1;
        mode = v.mode;
        expect_burst(v.base, v.len);
        start = 1'b1;
        base_addr = v.base;
        len = (ADDR_W + 1)'(v.len);
        step();
        start = 1'b0;
        chk("busy_after_start", busy, v.len != 0);
        for (int i = 0; i < 8 * v.len + 200 && n_done == d0; i++) begin
            start = v.poke != 0 && i == 2;
            if (start) begin
                base_addr = 11'h3A5;
                len = 12'd7;
            end
            step();
        end
        start = 1'b0;
        repeat (3) step();
        chk("done_count", n_done - d0, 1);
        chk("words", n_words - w0, v.exp_words);
        chk("reads", n_cen - c0, v.exp_words);
        chk("model_left", exp_d.size() + exp_a.size(), 0);
        if (v.exp_words > 0) begin
            chk("first_word", first_d, v.first_w);
            chk("last_word", last_d, v.last_w);
            if (v.mode == 0) begin
                chk("first_latency", first_val - first_cen, RD_LAT + 1);
                chk("no_bubbles", last_hs - first_hs + 1, v.len);
                chk("done_timing", done_cyc - last_hs, 1);
            end
        end
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        logic [ADDR_W-1:0] la;
        int w0, d0;
        tbl[0] = '{11'h010, 1,    0, 0, 1,    PAT + 32'h010, PAT + 32'h010};
        tbl[1] = '{11'h000, 32,   0, 0, 32,   PAT + 32'h000, PAT + 32'h01F};
        tbl[2] = '{11'h100, 16,   1, 0, 16,   PAT + 32'h100, PAT + 32'h10F};
        tbl[3] = '{11'h7FE, 4,    0, 0, 4,    PAT + 32'h7FE, PAT + 32'h001};
        tbl[4] = '{11'h123, 0,    0, 0, 0,    32'h0,         32'h0};
        tbl[5] = '{11'h200, 10,   0, 1, 10,   PAT + 32'h200, PAT + 32'h209};
        tbl[6] = '{11'h000, 2048, 0, 0, 2048, PAT + 32'h000, PAT + 32'h7FF};
        tbl[7] = '{11'h7F0, 20,   2, 0, 20,   PAT + 32'h7F0, PAT + 32'h003};
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = PAT + 32'(i);

        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cen", sram_cen, 1'b1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, 0);
`ifdef SRAM_RD_CHECK_EN
        chk("rst_chk_err", chk_err, 1'b0);
        chk("rst_chk_cnt", chk_cnt, 0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_burst(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.base = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
            v.len = int'($urandom_range(1, 40));
            v.mode = 2;
            v.poke = 0;
            v.exp_words = v.len;
            la = v.base + ADDR_W'(v.len - 1);
            v.first_w = PAT + 32'(v.base);
            v.last_w = PAT + 32'(la);
            run_burst(v);
        end

        // Abort a 20-word burst once five words have been delivered.
        mode = 0;
        w0 = n_words;
        d0 = n_done;
        expect_burst(11'h040, 20);
        start = 1'b1;
        base_addr = 11'h040;
        len = 12'd20;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && n_words < w0 + 5; i++) step();
        chk("words_before_abort", n_words - w0, 5);
        rst = 1'b1;
        step();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_cen", sram_cen, 1'b1);
        chk("abort_addr", sram_addr, 0);
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_last", out_last, 1'b0);
        chk("abort_data", out_data, 0);
        rst = 1'b0;
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
        disc = n_cen - n_words;
        repeat (10) step();
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_no_reads", n_cen - n_words - disc, 0);
        run_burst(tbl[0]);

`ifdef SRAM_RD_CHECK_EN
        mem[5] = 32'hDEADBEEF;
        run_burst('{11'h000, 8, 0, 0, 8, PAT, PAT + 32'h7});
        chk("chk_err_set", chk_err, 1'b1);
        chk("chk_cnt_one", chk_cnt, 1);
        mem[5] = PAT + 32'h5;
        run_burst('{11'h010, 2, 0, 0, 2, PAT + 32'h10, PAT + 32'h11});
        chk("chk_err_clear", chk_err, 1'b0);
        chk("chk_cnt_clear", chk_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
